// File: rtl/rt_pkg.sv
// Shared definitions for the rt_32b_dcnt countdown timer: state encoding and
// default widths.
package rt_pkg;

  localparam int CNT_W   = 32;
  localparam int PRESC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rt_state_e;

endpackage

// File: rtl/rt_32b_dcnt_if.sv
// Control/status bundle of the rt_32b_dcnt countdown timer.
// master: the side driving load/stop/ce; slave: the timer itself.
interface rt_32b_dcnt_if #(
  parameter int CNT_W   = rt_pkg::CNT_W,
  parameter int PRESC_W = rt_pkg::PRESC_W
);
  logic               rt_i_ce;
  logic               rt_i_load;
  logic [CNT_W-1:0]   rt_i_load_val;
  logic [PRESC_W-1:0] rt_i_presc;
  logic               rt_i_stop;
  logic [CNT_W-1:0]   rt_o_cnt;
  logic               rt_o_busy;
  logic               rt_o_tc;
  logic               rt_o_done;

  modport master (
    output rt_i_ce, rt_i_load, rt_i_load_val, rt_i_presc, rt_i_stop,
    input  rt_o_cnt, rt_o_busy, rt_o_tc, rt_o_done
  );

  modport slave (
    input  rt_i_ce, rt_i_load, rt_i_load_val, rt_i_presc, rt_i_stop,
    output rt_o_cnt, rt_o_busy, rt_o_tc, rt_o_done
  );
endinterface

// File: rtl/rt_presc_tick.sv
// Prescaler for rt_32b_dcnt: counts enabled cycles and emits a single-cycle
// tick every (presc_i+1) of them. clear_i restarts the phase at zero.
module rt_presc_tick #(
  parameter int PRESC_W = rt_pkg::PRESC_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic               ce_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick_o = ce_i && (cnt_q == presc_i);

  // Next phase: clear wins, wrap on tick, otherwise advance on enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (ce_i) begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  // Phase register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rt_32b_dcnt.sv
// rt_32b_dcnt: loadable down-counter with prescaled ticks and a one-cycle
// terminal-count pulse.
// Optional feature macro: RT_DCNT_AUTORELOAD_EN -- on terminal count the
// counter reloads the last loaded value and keeps running (periodic tc).
//
// state | meaning
// IDLE  | not counting; count held (after reset or stop)
// RUN   | decrementing on prescaled ticks; busy=1
// DONE  | reached zero (or loaded zero); done=1 until next load
module rt_32b_dcnt
  import rt_pkg::*;
#(
  parameter int CNT_W   = rt_pkg::CNT_W,
  parameter int PRESC_W = rt_pkg::PRESC_W
) (
  input  logic          rt_i_clk,
  input  logic          rt_i_rst,
  rt_32b_dcnt_if.slave  bus
);

  rt_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tc_q, tc_d;
  logic               run;
  logic               tick;
  logic               presc_clear;
`ifdef RT_DCNT_AUTORELOAD_EN
  logic [CNT_W-1:0]   reload_q, reload_d;
`endif

  assign run         = (state_q == ST_RUN);
  // Stop outside RUN must leave everything untouched, so only clear there.
  assign presc_clear = bus.rt_i_load || (bus.rt_i_stop && run);

  rt_presc_tick #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk_i   (rt_i_clk),
    .rst_i   (rt_i_rst),
    .clear_i (presc_clear),
    .ce_i    (bus.rt_i_ce && run),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  // Next-state and count update; priority load > stop > count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    tc_d     = 1'b0;
`ifdef RT_DCNT_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.rt_i_load) begin
      cnt_d   = bus.rt_i_load_val;
      presc_d = bus.rt_i_presc;
`ifdef RT_DCNT_AUTORELOAD_EN
      reload_d = bus.rt_i_load_val;
`endif
      if (bus.rt_i_load_val == '0) begin
        state_d = ST_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = ST_RUN;
      end
    end else if (bus.rt_i_stop && run) begin
      state_d = ST_IDLE;
    end else if (run && tick) begin
      // RUN never holds zero, but guard the compare so it cannot wrap.
      if (cnt_q <= CNT_W'(1)) begin
        tc_d = 1'b1;
`ifdef RT_DCNT_AUTORELOAD_EN
        cnt_d = reload_q;
`else
        cnt_d   = '0;
        state_d = ST_DONE;
`endif
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge rt_i_clk) begin
    if (rt_i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
    end
  end

`ifdef RT_DCNT_AUTORELOAD_EN
  // Reload value captured on every load.
  always_ff @(posedge rt_i_clk) begin
    if (rt_i_rst) begin
      reload_q <= '0;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus.rt_o_cnt  = cnt_q;
  assign bus.rt_o_tc   = tc_q;
  assign bus.rt_o_busy = (state_q == ST_RUN);
  assign bus.rt_o_done = (state_q == ST_DONE);

endmodule
